// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI4-Stream round-robin packet arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE arbitrates, BUSY forwards one packet)
//   id_width    : width of a source index for a given number of requesters
//   rr_pick     : reference rotating-priority pick over up to MAX_PORTS requesters
package axis_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int unsigned MAX_PORTS = 32;

   function automatic int unsigned id_width(input int unsigned ports);
      return (ports > 1) ? $clog2(ports) : 1;
   endfunction

   // Returns the first requester after 'last' in circular order; 'last' itself is
   // the lowest priority. Returns 'last' when nothing is requesting.
   function automatic int unsigned rr_pick(input logic [MAX_PORTS-1:0] req,
                                           input int unsigned last,
                                           input int unsigned ports);
      int unsigned idx;
      int unsigned pick;
      pick = last;
      for (int unsigned k = ports; k >= 1; k--) begin
         idx = (last + k) % ports;
         if (req[idx[4:0]]) pick = idx;
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Combinational rotating-priority encoder.
//   req_i      : request vector, one bit per requester
//   last_idx_i : most recently served requester (lowest priority this round)
//   gnt_idx_o  : index of the winning requester
//   gnt_vld_o  : at least one requester is active
// The request vector is duplicated: the low copy is masked to requesters strictly
// above last_idx_i, the high copy is unmasked. The lowest set bit of the doubled
// vector is the next requester in circular order, folded back modulo PORTS.
module rr_priority_encoder
   import axis_arb_pkg::*;
#(
   parameter int PORTS = 4,
   parameter int IDW   = id_width(PORTS)
) (
   input  logic [PORTS-1:0] req_i,
   input  logic [IDW-1:0]   last_idx_i,
   output logic [IDW-1:0]   gnt_idx_o,
   output logic             gnt_vld_o
);

   logic [PORTS-1:0]   mask;
   logic [2*PORTS-1:0] dbl;
   int                 pick;

   always_comb begin
      mask = '0;
      for (int i = 0; i < PORTS; i++) begin
         mask[i] = (i > int'(last_idx_i));
      end
      dbl  = {req_i, req_i & mask};
      pick = 0;
      for (int j = 2*PORTS-1; j >= 0; j--) begin
         if (dbl[j]) pick = j;
      end
      gnt_idx_o = IDW'(pick % PORTS);
      gnt_vld_o = |req_i;
   end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-level round-robin arbiter: PORTS AXI4-Stream requesters share one consumer.
// A grant is held from the first beat to tlast; output is a single register stage.
//   clk, rst                 : clock, synchronous active-high reset
//   s_axis_*                 : PORTS packed requester streams (port i at slice i)
//   m_axis_*                 : shared output stream, m_axis_tid = source port index
//   busy                     : high while a packet is being forwarded
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | arbitration cycle, no ready asserted, grant picked if any tvalid
//   BUSY  | forwarding granted port until its tlast beat is accepted
module axis_rr_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter int  PORTS       = 4,
   parameter int  DATA_WIDTH  = 64,
   parameter bit  KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int  KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
   parameter int  USER_WIDTH  = 1,
   localparam int ID_WIDTH    = id_width(PORTS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
   input  logic [PORTS-1:0]             s_axis_tvalid,
   output logic [PORTS-1:0]             s_axis_tready,
   input  logic [PORTS-1:0]             s_axis_tlast,
   input  logic [PORTS*USER_WIDTH-1:0]  s_axis_tuser,
   output logic [DATA_WIDTH-1:0]        m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic                         m_axis_tlast,
   output logic [ID_WIDTH-1:0]          m_axis_tid,
   output logic [USER_WIDTH-1:0]        m_axis_tuser,
   output logic                         busy
);

   arb_state_t            state_q, state_d;
   logic [ID_WIDTH-1:0]   grant_idx_q, grant_idx_d;
   logic [ID_WIDTH-1:0]   last_idx_q, last_idx_d;

   logic [ID_WIDTH-1:0]   enc_idx;
   logic                  enc_vld;

   logic [PORTS-1:0]      grant_oh;
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [KEEP_WIDTH-1:0] sel_keep;
   logic [USER_WIDTH-1:0] sel_user;
   logic [KEEP_WIDTH-1:0] load_keep;

   logic                  out_slot;
   logic                  beat_loaded;
   logic                  pkt_done;

   logic [DATA_WIDTH-1:0] m_data_q;
   logic [KEEP_WIDTH-1:0] m_keep_q;
   logic                  m_valid_q;
   logic                  m_last_q;
   logic [ID_WIDTH-1:0]   m_id_q;
   logic [USER_WIDTH-1:0] m_user_q;

   rr_priority_encoder #(
      .PORTS (PORTS),
      .IDW   (ID_WIDTH)
   ) u_rr_enc (
      .req_i      (s_axis_tvalid),
      .last_idx_i (last_idx_q),
      .gnt_idx_o  (enc_idx),
      .gnt_vld_o  (enc_vld)
   );

   // AND-OR mux on the one-hot grant; only the granted slice reaches the output.
   always_comb begin
      grant_oh  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      sel_user  = '0;
      for (int i = 0; i < PORTS; i++) begin
         grant_oh[i] = (grant_idx_q == ID_WIDTH'(i));
         if (grant_oh[i]) begin
            sel_valid = sel_valid | s_axis_tvalid[i];
            sel_last  = sel_last  | s_axis_tlast[i];
            sel_data  = sel_data  | s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_keep  = sel_keep  | s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            sel_user  = sel_user  | s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
         end
      end
   end

   assign load_keep   = KEEP_ENABLE ? sel_keep : {KEEP_WIDTH{1'b1}};
   assign out_slot    = !m_valid_q || m_axis_tready;
   assign beat_loaded = (state_q == BUSY) && sel_valid && out_slot;
   assign pkt_done    = beat_loaded && sel_last;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_idx_q <= '0;
         last_idx_q  <= ID_WIDTH'(PORTS - 1);
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         last_idx_q  <= last_idx_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      last_idx_d  = last_idx_q;
      case (state_q)
         IDLE: begin
            if (enc_vld) begin
               state_d     = BUSY;
               grant_idx_d = enc_idx;
            end
         end
         BUSY: begin
            if (pkt_done) begin
               state_d    = IDLE;
               last_idx_d = grant_idx_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      s_axis_tready = '0;
      busy          = 1'b0;
      if (state_q == BUSY) begin
         busy          = 1'b1;
         s_axis_tready = grant_oh & {PORTS{out_slot}};
      end
   end

   // Output register: fields only load on an accepted beat, so they hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_keep_q  <= '0;
         m_last_q  <= 1'b0;
         m_id_q    <= '0;
         m_user_q  <= '0;
      end else begin
         m_valid_q <= beat_loaded || (m_valid_q && !m_axis_tready);
         if (beat_loaded) begin
            m_data_q <= sel_data;
            m_keep_q <= load_keep;
            m_last_q <= sel_last;
            m_id_q   <= grant_idx_q;
            m_user_q <= sel_user;
         end
      end
   end

   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tkeep  = m_keep_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tid    = m_id_q;
   assign m_axis_tuser  = m_user_q;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed self-checking bench for axis_rr_packet_arbiter (PORTS=4, 64-bit data).
module tb_axis_rr_packet_arbiter;

   localparam int P  = 4;
   localparam int DW = 64;
   localparam int KW = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [P*DW-1:0] s_tdata  = '0;
   logic [P*KW-1:0] s_tkeep  = '0;
   logic [P-1:0]    s_tvalid = '0;
   logic [P-1:0]    s_tready;
   logic [P-1:0]    s_tlast  = '0;
   logic [P-1:0]    s_tuser  = '0;
   logic [DW-1:0]   m_tdata;
   logic [KW-1:0]   m_tkeep;
   logic            m_tvalid;
   logic            m_tready = 1'b1;
   logic            m_tlast;
   logic [1:0]      m_tid;
   logic [0:0]      m_tuser;
   logic            busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [63:0] q_data[$];
   logic [1:0]  q_tid[$];
   logic        q_last[$];
   logic        q_user[$];
   int          q_cyc[$];

   logic        stall_prev = 1'b0;
   logic [63:0] hold_data;
   logic [1:0]  hold_tid;
   logic        p1_done;
   int          pkt, pp, kk, bb, n;

   axis_rr_packet_arbiter #(
      .PORTS      (P),
      .DATA_WIDTH (DW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .s_axis_tuser  (s_tuser),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .m_axis_tid    (m_tid),
      .m_axis_tuser  (m_tuser),
      .busy          (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Output collector plus hold-stability check while stalled.
   always @(negedge clk) begin
      if (rst === 1'b0 && stall_prev) begin
         chk("hold_valid", m_tvalid, 1);
         chk("hold_data", m_tdata, hold_data);
         chk("hold_tid", m_tid, hold_tid);
      end
      stall_prev = (rst === 1'b0) && (m_tvalid === 1'b1) && (m_tready === 1'b0);
      hold_data  = m_tdata;
      hold_tid   = m_tid;
      if (rst === 1'b0 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
         q_data.push_back(m_tdata);
         q_tid.push_back(m_tid);
         q_last.push_back(m_tlast);
         q_user.push_back(m_tuser[0]);
         q_cyc.push_back(cyc);
      end
   end

   task automatic clear_q();
      q_data.delete();
      q_tid.delete();
      q_last.delete();
      q_user.delete();
      q_cyc.delete();
   endtask

   task automatic send_pkt(input int port, input int base, input int len,
                           input int stall_after, input int stall_cyc);
      logic hs;
      int   tmo;
      for (int b = 0; b < len; b++) begin
         if (b == stall_after && stall_cyc > 0) begin
            s_tvalid[port] = 1'b0;
            repeat (stall_cyc) step();
         end
         s_tdata[port*DW +: DW] = DW'(base + b);
         s_tkeep[port*KW +: KW] = 8'hFF;
         s_tlast[port]  = (b == len - 1);
         s_tuser[port]  = b[0];
         s_tvalid[port] = 1'b1;
         hs  = 1'b0;
         tmo = 0;
         while (!hs && tmo < 200) begin
            @(negedge clk);
            hs = s_tready[port];
            @(posedge clk);
            #1;
            tmo++;
         end
         chk("handshake_timeout", hs, 1);
      end
      s_tvalid[port] = 1'b0;
      s_tlast[port]  = 1'b0;
   endtask

   task automatic wait_beats(input int want);
      int t;
      t = 0;
      while (q_data.size() < want && t < 150) begin
         step();
         t++;
      end
      repeat (3) step();
      chk("beat_count", q_data.size(), want);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held 3 cycles with every port requesting.
      rst      = 1'b1;
      s_tvalid = '1;
      m_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_m_tvalid", m_tvalid, 0);
         chk("rst_s_tready", s_tready, 0);
         chk("rst_busy", busy, 0);
      end
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tid", m_tid, 0);
      rst      = 1'b0;
      s_tvalid = '0;
      step();
      clear_q();

      // Single port: port 2, beats A0..A3.
      s_tdata[2*DW +: DW] = 64'hA0;
      s_tkeep[2*KW +: KW] = 8'h0F;
      s_tlast[2]  = 1'b0;
      s_tvalid[2] = 1'b1;
      step();
      chk("sp_first_idle_valid", m_tvalid, 0);
      chk("sp_busy", busy, 1);
      chk("sp_ready", s_tready, 4'b0100);
      step();
      chk("sp_b0_valid", m_tvalid, 1);
      chk("sp_b0_data", m_tdata, 64'hA0);
      chk("sp_b0_tid", m_tid, 2);
      chk("sp_b0_last", m_tlast, 0);
      chk("sp_b0_keep", m_tkeep, 8'h0F);
      s_tdata[2*DW +: DW] = 64'hA1;
      step();
      chk("sp_b1_data", m_tdata, 64'hA1);
      chk("sp_b1_last", m_tlast, 0);
      s_tdata[2*DW +: DW] = 64'hA2;
      step();
      chk("sp_b2_data", m_tdata, 64'hA2);
      chk("sp_b2_last", m_tlast, 0);
      s_tdata[2*DW +: DW] = 64'hA3;
      s_tlast[2] = 1'b1;
      step();
      chk("sp_b3_data", m_tdata, 64'hA3);
      chk("sp_b3_last", m_tlast, 1);
      chk("sp_b3_tid", m_tid, 2);
      s_tvalid[2] = 1'b0;
      s_tlast[2]  = 1'b0;
      step();
      chk("sp_end_valid", m_tvalid, 0);
      chk("sp_end_busy", busy, 0);

      // Round robin: restart priority at port 0, all ports send two 2-beat packets.
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_q();
      fork
         begin send_pkt(0, 16*0, 2, -1, 0); send_pkt(0, 16*0 + 4, 2, -1, 0); end
         begin send_pkt(1, 16*1, 2, -1, 0); send_pkt(1, 16*1 + 4, 2, -1, 0); end
         begin send_pkt(2, 16*2, 2, -1, 0); send_pkt(2, 16*2 + 4, 2, -1, 0); end
         begin send_pkt(3, 16*3, 2, -1, 0); send_pkt(3, 16*3 + 4, 2, -1, 0); end
      join
      wait_beats(16);
      for (int i = 0; i < 16; i++) begin
         if (i < q_data.size()) begin
            pkt = i / 2;
            pp  = pkt % 4;
            kk  = pkt / 4;
            bb  = i % 2;
            chk("rr_tid", q_tid[i], pp);
            chk("rr_data", q_data[i], 16*pp + 4*kk + bb);
            chk("rr_last", q_last[i], (bb == 1));
            chk("rr_user", q_user[i], bb);
         end
      end
      if (q_cyc.size() >= 16) begin
         for (int j = 0; j < 8; j++) chk("rr_gap_in_pkt", q_cyc[2*j+1] - q_cyc[2*j], 1);
         for (int j = 0; j < 7; j++) chk("rr_gap_pkt", q_cyc[2*j+2] - q_cyc[2*j], 3);
      end

      // Backpressure: m_tready toggles 1,0,1,0 during an 8-beat packet from port 1.
      clear_q();
      fork
         send_pkt(1, 'h50, 8, -1, 0);
         begin
            for (int i = 0; i < 40; i++) begin
               m_tready = (i % 2 == 0);
               step();
            end
            m_tready = 1'b1;
         end
      join
      wait_beats(8);
      for (int i = 0; i < 8; i++) begin
         if (i < q_data.size()) begin
            chk("bp_data", q_data[i], 'h50 + i);
            chk("bp_tid", q_tid[i], 1);
            chk("bp_last", q_last[i], (i == 7));
         end
      end

      // Sticky grant: port 1 stalls mid-packet while port 0 requests.
      clear_q();
      p1_done = 1'b0;
      fork
         begin send_pkt(1, 'h60, 6, 2, 5); p1_done = 1'b1; end
         begin step(); step(); step(); send_pkt(0, 'h70, 1, -1, 0); end
         begin
            n = 0;
            while (!p1_done && n < 200) begin
               @(negedge clk);
               if (!p1_done) chk("sticky_p0_ready", s_tready[0], 0);
               n++;
            end
         end
      join
      wait_beats(7);
      if (q_data.size() >= 7) begin
         for (int i = 0; i < 6; i++) begin
            chk("sticky_p1_data", q_data[i], 'h60 + i);
            chk("sticky_p1_tid", q_tid[i], 1);
            chk("sticky_p1_last", q_last[i], (i == 5));
         end
         chk("sticky_p0_data", q_data[6], 'h70);
         chk("sticky_p0_tid", q_tid[6], 0);
         chk("single_beat_last", q_last[6], 1);
         chk("sticky_p0_gap", q_cyc[6] - q_cyc[5], 2);
      end
      chk("single_beat_busy_end", busy, 0);

      // Mid-packet reset: port 3, reset after beat 2 of 5.
      m_tready = 1'b1;
      s_tdata[3*DW +: DW] = 64'hD0;
      s_tlast[3]  = 1'b0;
      s_tvalid[3] = 1'b1;
      step();
      chk("mr_busy", busy, 1);
      step();
      chk("mr_b0_data", m_tdata, 64'hD0);
      s_tdata[3*DW +: DW] = 64'hD1;
      step();
      chk("mr_b1_data", m_tdata, 64'hD1);
      chk("mr_b1_tid", m_tid, 3);
      rst = 1'b1;
      s_tdata[3*DW +: DW] = 64'hD2;
      step();
      chk("mr_valid", m_tvalid, 0);
      chk("mr_data", m_tdata, 0);
      chk("mr_tid", m_tid, 0);
      chk("mr_last", m_tlast, 0);
      chk("mr_busy_clr", busy, 0);
      chk("mr_ready", s_tready, 0);
      rst = 1'b0;
      s_tvalid[3] = 1'b0;
      step();
      clear_q();
      send_pkt(3, 'hE0, 2, -1, 0);
      wait_beats(2);
      if (q_data.size() >= 2) begin
         chk("mr_fresh_d0", q_data[0], 64'hE0);
         chk("mr_fresh_d1", q_data[1], 64'hE1);
         chk("mr_fresh_tid0", q_tid[0], 3);
         chk("mr_fresh_tid1", q_tid[1], 3);
         chk("mr_fresh_last", {q_last[0], q_last[1]}, 2'b01);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
